// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle between a requester and serial_adder_ctrl.
// Ports: start/a/b/cin flow requester -> adder; busy/done/sum/cout (and ovf
// when SERIAL_ADDER_OVF_EN is defined) flow adder -> requester.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice stepped LSB-first over WIDTH cycles.
// Latency WIDTH cycles from accepted start to the one-cycle done pulse; one add
// per WIDTH+1 cycles. No backpressure: start is sampled only in IDLE and in the
// done cycle, and is dropped otherwise.
// Ports: clk, rst (sync, active-high), bus (slave side of serial_adder_ctrl_if).
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the registered signed ovf.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Only WIDTH-1 partial bits are kept; the final bit goes straight to sum.
   logic [WIDTH-2:0] res_sh;
   logic             c;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             s;
   logic             c_nxt;
   logic [WIDTH-1:0] res_nxt;

   assign s       = a_sh[0] ^ b_sh[0] ^ c;
   assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
   assign res_nxt = {s, res_sh};

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         case (state)
            // The done cycle also accepts start so a held start yields
            // back-to-back adds every WIDTH+1 cycles.
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  c     <= bus.cin;
                  cnt   <= '0;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt[WIDTH-1:1];
               c      <= c_nxt;
               if (cnt == LAST) begin
                  cnt    <= '0;
                  sum_q  <= res_nxt;
                  cout_q <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                  // c is the carry into the MSB while the MSB is processed.
                  ovf_q  <= c ^ c_nxt;
`endif
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == S_RUN);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference: plain (W+1)-bit addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   // Reference signed overflow: same-sign operands producing a result of the other sign.
   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] r;
      r = ref_add(x, y, ci);
      return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   // Drives one operation from a negedge in IDLE and observes it; no comparisons.
   // lat = posedges after the start edge until done is seen (-1 on timeout).
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        output int lat, output int busy_cyc, output logic early_chg,
                        output logic after_act);
      logic [W-1:0] prev;
      bus.a = ia; bus.b = ib; bus.cin = ic; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      prev = bus.sum; lat = -1; busy_cyc = 0; early_chg = 1'b0;
      for (int n = 0; n < 4*W; n++) begin
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.busy) busy_cyc++;
         if (bus.sum !== prev) early_chg = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      after_act = bus.done | bus.busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
      rst = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
      logic [W-1:0] vb [4] = '{8'h00, 8'h01, 8'h5A, 8'h11};
      logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'h4D};
      logic         ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int lat, bc; logic early, after;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vc[i], lat, bc, early, after);
         checks++; if (lat !== W) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W); end
         checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
         checks++; if (bus.cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
         checks++; if (bc !== W) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, W); end
         checks++; if (after !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got=%b exp=0", i, after); end
         checks++; if (early !== 1'b0) begin errors++; $display("FAIL dir%0d_sum_early got=%b exp=0", i, early); end
      end
   endtask

   task automatic test_random();
      int lat, bc; logic early, after;
      logic [W-1:0] x, y; logic ci; logic [W:0] r;
      for (int i = 0; i < 30; i++) begin
         x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
         if (i == 0) begin x = 8'hFF; y = 8'hFF; ci = 1'b1; end
         r = ref_add(x, y, ci);
         do_op(x, y, ci, lat, bc, early, after);
         checks++; if (lat !== W) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, W); end
         checks++; if ({bus.cout, bus.sum} !== r) begin errors++; $display("FAIL rnd%0d_result a=%h b=%h cin=%b got=%b_%h exp=%b_%h", i, x, y, ci, bus.cout, bus.sum, r[W], r[W-1:0]); end
         checks++; if (after !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_width got=%b exp=0", i, after); end
`ifdef SERIAL_ADDER_OVF_EN
         checks++; if (bus.ovf !== ref_ovf(x, y, ci)) begin errors++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, bus.ovf, ref_ovf(x, y, ci)); end
`endif
      end
   endtask

   task automatic test_ignore_start();
      int ndone, first; logic [W-1:0] s1;
      ndone = 0; first = -1; s1 = '0;
      bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
      for (int n = 0; n < 3*W; n++) begin
         @(negedge clk);
         bus.start = (n == 2);
         if (n == 2) begin bus.a = 8'h01; bus.b = 8'h01; end
         if (bus.done) begin
            ndone++;
            if (first < 0) begin first = n; s1 = bus.sum; end
         end
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
      checks++; if (first !== W) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", first, W); end
      checks++; if (s1 !== 8'h30) begin errors++; $display("FAIL ignore_sum got=%h exp=30", s1); end
   endtask

   task automatic test_back_to_back();
      int d1, d2; logic [W-1:0] s1, s2; logic c1, c2; logic [W:0] r1, r2;
      d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
      r1 = ref_add(8'h21, 8'h43, 1'b0);
      r2 = ref_add(8'h0F, 8'hF1, 1'b1);
      bus.a = 8'h21; bus.b = 8'h43; bus.cin = 1'b0; bus.start = 1'b1;
      for (int n = 0; n < 2*W + 6; n++) begin
         @(negedge clk);
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = n; s1 = bus.sum; c1 = bus.cout;
               bus.a = 8'h0F; bus.b = 8'hF1; bus.cin = 1'b1;
            end else if (d2 < 0) begin
               d2 = n; s2 = bus.sum; c2 = bus.cout;
            end
         end
         if (n == W + 1) bus.start = 1'b0;
      end
      checks++; if (d1 !== W) begin errors++; $display("FAIL b2b_first_done got=%0d exp=%0d", d1, W); end
      checks++; if (d2 !== 2*W + 1) begin errors++; $display("FAIL b2b_second_done got=%0d exp=%0d", d2, 2*W + 1); end
      checks++; if ({c1, s1} !== r1) begin errors++; $display("FAIL b2b_first_result got=%b_%h exp=%b_%h", c1, s1, r1[W], r1[W-1:0]); end
      checks++; if ({c2, s2} !== r2) begin errors++; $display("FAIL b2b_second_result got=%b_%h exp=%b_%h", c2, s2, r2[W], r2[W-1:0]); end
   endtask

   task automatic test_abort();
      int lat, bc, ndone; logic early, after;
      do_op(8'hF3, 8'h11, 1'b0, lat, bc, early, after);
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL abort_sum got=%h exp=00", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL abort_cout got=%b exp=0", bus.cout); end
      ndone = 0;
      for (int n = 0; n < 2*W; n++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
      do_op(8'h3C, 8'h11, 1'b0, lat, bc, early, after);
      checks++; if (lat !== W) begin errors++; $display("FAIL abort_recover_latency got=%0d exp=%0d", lat, W); end
      checks++; if (bus.sum !== 8'h4D) begin errors++; $display("FAIL abort_recover_sum got=%h exp=4D", bus.sum); end
   endtask

`ifdef SERIAL_ADDER_OVF_EN
   task automatic test_ovf();
      logic [W-1:0] va [3] = '{8'h7F, 8'hFF, 8'h80};
      logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'h80};
      logic [W-1:0] es [3] = '{8'h80, 8'h00, 8'h00};
      logic         ec [3] = '{1'b0, 1'b1, 1'b1};
      logic         eo [3] = '{1'b1, 1'b0, 1'b1};
      int lat, bc; logic early, after;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], 1'b0, lat, bc, early, after);
         checks++; if (bus.sum !== es[i]) begin errors++; $display("FAIL ovf%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
         checks++; if (bus.cout !== ec[i]) begin errors++; $display("FAIL ovf%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
         checks++; if (bus.ovf !== eo[i]) begin errors++; $display("FAIL ovf%0d_ovf got=%b exp=%b", i, bus.ovf, eo[i]); end
      end
   endtask
`endif

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_abort();
`ifdef SERIAL_ADDER_OVF_EN
      test_ovf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
